fetch_unit: RTL and testbench

//   Instruction-fetch front end: owns the PC, requests instructions from instruction memory and

---
 rtl/fetch_unit_if.sv | 23 ++
 rtl/fetch_unit.sv | 180 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and imem.
// One request is outstanding at a time: ImemReq/ImemAddr are held until
// ImemAck pulses for one cycle with ImemRData valid.
interface fetch_unit_if;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck;
  logic [31:0] ImemRData;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemAck,
    input  ImemRData
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemAck,
    output ImemRData
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end. Owns the PC, issues one imem request at a time,
// presents fetched words to the fetch/decode register and parks a response in
// a one-entry skid buffer when that register is stalled. Redirects flush the
// output and skid; a request already in flight on the wrong path is drained
// (KILL) before fetching resumes at the saved target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         Reset_n,
  input  logic         StallF,
  input  logic         RedirectF,
  input  logic [31:0]  RedirectPC,
  fetch_unit_if.master imem,
  output logic [31:0]  InstrF,
  output logic [31:0]  PCF,
  output logic         ValidF
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2,
    KILL = 2'd3
  } state_t;

  state_t      state_q, state_d;

  // Fetch address; in KILL this still holds the abandoned request's address.
  logic [31:0] pc_q, pc_d;
  // Redirect target parked while a wrong-path request drains.
  logic [31:0] tgt_q, tgt_d;

  // Fetch/decode-facing output registers.
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcf_q, pcf_d;
  logic        valid_q, valid_d;

  // Skid entry; it is occupied exactly when the FSM is in FULL.
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic        consume;
  logic        out_free;
  logic        redirect;
  logic        ack;
  logic [31:0] redirect_pc;

  // Redirect targets are word addresses; the low two bits are discarded.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Sequential fetch address, wrapping modulo 2^32.
  function automatic logic [31:0] next_word(input logic [31:0] addr);
    return addr + 32'd4;
  endfunction

  assign consume     = valid_q & ~StallF;
  assign out_free    = ~valid_q | consume;
  // IDLE lasts one cycle after reset and neither redirects nor acks apply there.
  assign redirect    = RedirectF & (state_q != IDLE);
  assign ack         = imem.ImemAck & ((state_q == WAIT) | (state_q == KILL));
  assign redirect_pc = word_align(RedirectPC);

  assign imem.ImemReq  = (state_q == WAIT) | (state_q == KILL);
  assign imem.ImemAddr = pc_q;

  assign InstrF = instr_q;
  assign PCF    = pcf_q;
  assign ValidF = valid_q;

  // State register plus PC and output registers, cleared asynchronously.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pcf_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcf_q   <= pcf_d;
      valid_q <= valid_d;
    end
  end

  // Skid data and saved redirect target; their validity is carried by the state.
  always_ff @(posedge CLK) begin
    tgt_q        <= tgt_d;
    skid_instr_q <= skid_instr_d;
    skid_pc_q    <= skid_pc_d;
  end

  // Next-state and register-update decisions; redirect outranks stall and ack.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    instr_d      = instr_q;
    pcf_d        = pcf_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    case (state_q)
      IDLE: begin
        state_d = WAIT;
      end

      WAIT: begin
        if (redirect) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (ack) begin
            // Response lands this cycle and is simply dropped.
            pc_d    = redirect_pc;
            state_d = WAIT;
          end else begin
            // Keep the old address on the bus until its ack drains.
            tgt_d   = redirect_pc;
            state_d = KILL;
          end
        end else if (ack) begin
          pc_d = next_word(pc_q);
          if (out_free) begin
            instr_d = imem.ImemRData;
            pcf_d   = pc_q;
            valid_d = 1'b1;
          end else begin
            skid_instr_d = imem.ImemRData;
            skid_pc_d    = pc_q;
            state_d      = FULL;
          end
        end else if (consume) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end

      FULL: begin
        if (redirect) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          pc_d    = redirect_pc;
          state_d = WAIT;
        end else if (!StallF) begin
          // Output is consumed this cycle; refill it from the skid entry.
          instr_d = skid_instr_q;
          pcf_d   = skid_pc_q;
          valid_d = 1'b1;
          state_d = WAIT;
        end
      end

      KILL: begin
        if (redirect) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          tgt_d   = redirect_pc;
          if (ack) begin
            pc_d    = redirect_pc;
            state_d = WAIT;
          end
        end else if (ack) begin
          pc_d    = tgt_q;
          state_d = WAIT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations followed
// by randomized stall/redirect/latency traffic, all checked against a
// program-order model of what the fetch stream must look like.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        CLK;
  logic        Reset_n;
  logic        StallF;
  logic        RedirectF;
  logic [31:0] RedirectPC;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic        ValidF;

  fetch_unit_if imem ();

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .StallF     (StallF),
    .RedirectF  (RedirectF),
    .RedirectPC (RedirectPC),
    .imem       (imem),
    .InstrF     (InstrF),
    .PCF        (PCF),
    .ValidF     (ValidF)
  );

  int total = 0;
  int bad   = 0;

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a ^ 32'h5A5A_C3C3) + 32'h1234_0001;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  // ---------------- memory responder ----------------
  int lat_mode  = 0;   // 0: zero-wait, 1: fixed 3, 2: random 0..3
  bit force_ack = 1'b0;
  int wait_cnt  = 0;
  int cur_lat   = 0;

  function automatic int pick_lat(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 3;
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    imem.ImemAck   = 1'b0;
    imem.ImemRData = 32'h0;
    forever begin
      @(posedge CLK);
      #1;
      if (force_ack) begin
        imem.ImemAck   = 1'b1;
        imem.ImemRData = 32'hDEAD_BEEF;
        wait_cnt       = 0;
      end else if (!Reset_n || !imem.ImemReq) begin
        imem.ImemAck = 1'b0;
        wait_cnt     = 0;
        cur_lat      = pick_lat(lat_mode);
      end else if (wait_cnt >= cur_lat) begin
        imem.ImemAck   = 1'b1;
        imem.ImemRData = memf(imem.ImemAddr);
        wait_cnt       = 0;
        cur_lat        = pick_lat(lat_mode);
      end else begin
        imem.ImemAck = 1'b0;
        wait_cnt++;
      end
    end
  end

  // ---------------- reference model and per-cycle compare ----------------
  logic [31:0] exp_out;     // PC of the next instruction downstream must receive
  logic [31:0] exp_fetch;   // next correct-path address whose ack is accepted
  bit          stale;       // an outstanding request belongs to a flushed path
  bit          prev_hold;
  logic [31:0] prev_addr;
  bit          redir_last;
  int          since_rst;
  int          n_consumed = 0;

  initial begin
    exp_out    = RESET_PC;
    exp_fetch  = RESET_PC;
    stale      = 1'b0;
    prev_hold  = 1'b0;
    prev_addr  = 32'h0;
    redir_last = 1'b0;
    since_rst  = 0;
    forever begin
      @(negedge CLK);
      if (!Reset_n) begin
        chk("rst_req",   32'(imem.ImemReq), 32'd0);
        chk("rst_valid", 32'(ValidF), 32'd0);
        chk("rst_instr", InstrF, NOP);
        chk("rst_pcf",   PCF, 32'h0);
        exp_out    = RESET_PC;
        exp_fetch  = RESET_PC;
        stale      = 1'b0;
        prev_hold  = 1'b0;
        redir_last = 1'b0;
        since_rst  = 0;
      end else begin
        if (since_rst == 0) begin
          chk("idle_req",   32'(imem.ImemReq), 32'd0);
          chk("idle_valid", 32'(ValidF), 32'd0);
        end
        if (since_rst == 1) begin
          chk("first_req",  32'(imem.ImemReq), 32'd1);
          chk("first_addr", imem.ImemAddr, RESET_PC);
        end
        if (prev_hold) begin
          chk("hold_req",  32'(imem.ImemReq), 32'd1);
          chk("hold_addr", imem.ImemAddr, prev_addr);
        end
        if (redir_last) chk("flush_valid", 32'(ValidF), 32'd0);
        if (!ValidF) chk("nop_instr", InstrF, NOP);
        if (imem.ImemReq) chk("addr_align", 32'(imem.ImemAddr[1:0]), 32'd0);

        if (ValidF && !StallF) begin
          chk("stream_pc",    PCF, exp_out);
          chk("stream_instr", InstrF, memf(PCF));
          exp_out = exp_out + 32'd4;
          n_consumed++;
        end

        if (RedirectF && since_rst != 0) begin
          exp_out   = {RedirectPC[31:2], 2'b00};
          exp_fetch = {RedirectPC[31:2], 2'b00};
          stale     = imem.ImemReq && !imem.ImemAck;
          redir_last = 1'b1;
        end else begin
          redir_last = 1'b0;
          if (imem.ImemReq && imem.ImemAck && since_rst != 0) begin
            if (stale) begin
              stale = 1'b0;
            end else begin
              chk("fetch_addr", imem.ImemAddr, exp_fetch);
              exp_fetch = exp_fetch + 32'd4;
            end
          end
        end

        prev_hold = imem.ImemReq && !imem.ImemAck;
        prev_addr = imem.ImemAddr;
        if (since_rst < 1000) since_rst++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit st, input bit rd, input logic [31:0] tg);
    @(posedge CLK);
    #2;
    StallF     = st;
    RedirectF  = rd;
    RedirectPC = tg;
    @(negedge CLK);
  endtask

  // Ends at the negedge of the IDLE cycle that follows release.
  task automatic do_reset();
    @(posedge CLK);
    #3;
    Reset_n   = 1'b0;
    StallF    = 1'b0;
    RedirectF = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    Reset_n = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    Reset_n    = 1'b1;
    StallF     = 1'b0;
    RedirectF  = 1'b0;
    RedirectPC = 32'h0;
    #1 Reset_n = 1'b0;

    // Zero-wait stream from reset: PCF 0,4,8,12 on consecutive cycles.
    lat_mode = 0;
    do_reset();
    chk("t1_valid_c0", 32'(ValidF), 32'd0);
    step(0, 0, 0);
    chk("t1_valid_c1", 32'(ValidF), 32'd0);
    chk("t1_req_c1", 32'(imem.ImemReq), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0);
      chk("t1_valid", 32'(ValidF), 32'd1);
      chk("t1_pcf", PCF, 32'(i * 4));
      chk("t1_instr", InstrF, memf(32'(i * 4)));
    end

    // Three stalled cycles fill the skid; release continues without gap.
    step(1, 0, 0);
    chk("t2_pcf_c6", PCF, 32'd16);
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0);
      chk("t2_req_full", 32'(imem.ImemReq), 32'd0);
      chk("t2_pcf_frozen", PCF, 32'd16);
      chk("t2_valid_frozen", 32'(ValidF), 32'd1);
    end
    step(0, 0, 0);
    chk("t2_pcf_c9", PCF, 32'd16);
    step(0, 0, 0);
    chk("t2_pcf_skid", PCF, 32'd20);
    chk("t2_instr_skid", InstrF, memf(32'd20));
    step(0, 0, 0);
    chk("t2_pcf_next", PCF, 32'd24);

    // Redirect during a 3-cycle-latency request: the response is drained.
    lat_mode = 1;
    do_reset();
    step(0, 0, 0);
    chk("t3_addr_c1", imem.ImemAddr, 32'h0);
    step(0, 1, 32'h0000_0103);
    chk("t3_addr_c2", imem.ImemAddr, 32'h0);
    step(0, 0, 0);
    chk("t3_kill_req", 32'(imem.ImemReq), 32'd1);
    chk("t3_kill_addr", imem.ImemAddr, 32'h0);
    step(0, 0, 0);
    chk("t3_kill_valid", 32'(ValidF), 32'd0);
    step(0, 0, 0);
    chk("t3_new_addr", imem.ImemAddr, 32'h0000_0100);
    chk("t3_new_req", 32'(imem.ImemReq), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      chk("t3_wait_valid", 32'(ValidF), 32'd0);
    end
    step(0, 0, 0);
    chk("t3_valid", 32'(ValidF), 32'd1);
    chk("t3_pcf", PCF, 32'h0000_0100);
    chk("t3_instr", InstrF, memf(32'h0000_0100));

    // Redirect with stall and ack in the same cycle, from WAIT then from FULL.
    lat_mode = 0;
    do_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 1, 32'h0000_0200);
    chk("t4_pcf_c3", PCF, 32'd4);
    step(0, 0, 0);
    chk("t4_valid", 32'(ValidF), 32'd0);
    chk("t4_instr", InstrF, NOP);
    chk("t4_addr", imem.ImemAddr, 32'h0000_0200);
    step(0, 0, 0);
    chk("t4_pcf_tgt", PCF, 32'h0000_0200);
    step(1, 0, 0);
    chk("t4_pcf_c6", PCF, 32'h0000_0204);
    step(1, 1, 32'h0000_0300);
    chk("t4_full_req", 32'(imem.ImemReq), 32'd0);
    step(0, 0, 0);
    chk("t4b_valid", 32'(ValidF), 32'd0);
    chk("t4b_addr", imem.ImemAddr, 32'h0000_0300);
    step(0, 0, 0);
    chk("t4b_pcf", PCF, 32'h0000_0300);
    chk("t4b_valid_on", 32'(ValidF), 32'd1);

    // Wrap from the top of the address space; low target bits are dropped.
    step(0, 1, 32'hFFFF_FFFF);
    step(0, 0, 0);
    chk("t5_addr_top", imem.ImemAddr, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("t5_addr_wrap", imem.ImemAddr, 32'h0000_0000);
    chk("t5_pcf_top", PCF, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("t5_pcf_wrap", PCF, 32'h0000_0000);

    // Asynchronous reset while draining a killed request.
    lat_mode = 1;
    do_reset();
    step(0, 0, 0);
    step(0, 1, 32'h0000_0400);
    step(0, 0, 0);
    chk("t6_kill_req", 32'(imem.ImemReq), 32'd1);
    @(posedge CLK);
    #3;
    Reset_n   = 1'b0;
    force_ack = 1'b1;
    #1;
    chk("t6_async_req", 32'(imem.ImemReq), 32'd0);
    chk("t6_async_valid", 32'(ValidF), 32'd0);
    chk("t6_async_instr", InstrF, NOP);
    chk("t6_async_pcf", PCF, 32'h0);
    repeat (2) @(posedge CLK);
    #2;
    Reset_n = 1'b1;
    @(negedge CLK);
    force_ack = 1'b0;
    chk("t6_idle_valid", 32'(ValidF), 32'd0);
    step(0, 0, 0);
    chk("t6_first_addr", imem.ImemAddr, RESET_PC);
    chk("t6_first_valid", 32'(ValidF), 32'd0);
    repeat (3) step(0, 0, 0);
    chk("t6_valid_pre", 32'(ValidF), 32'd0);
    step(0, 0, 0);
    chk("t6_valid", 32'(ValidF), 32'd1);
    chk("t6_instr", InstrF, memf(RESET_PC));

    // Randomized traffic: stalls, redirects and latencies.
    n_consumed = 0;
    for (int ph = 0; ph < 2; ph++) begin
      lat_mode = (ph == 0) ? 2 : 0;
      do_reset();
      for (int n = 0; n < 2000; n++) begin
        logic [31:0] tg;
        bit          st;
        bit          rd;
        st = ($urandom_range(0, 99) < 30);
        rd = ($urandom_range(0, 99) < 6);
        tg = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                         : $urandom;
        if ($urandom_range(0, 999) == 0) do_reset();
        else step(st, rd, tg);
      end
    end
    chk("rand_progress", 32'(n_consumed > 400), 32'd1);

    step(0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
